// File: rtl/clock_pkg.sv
// Shared definitions for the clock monitor.
//   mon_state_t     : monitor FSM states (idle, armed, measuring, lost)
//   DefaultCntW     : default period counter width
//   DefaultTimeout  : default loss-of-clock timeout in clk cycles
package clock_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure,
        StLost
    } mon_state_t;

    localparam int unsigned DefaultCntW    = 16;
    localparam int unsigned DefaultTimeout = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a rising-edge detector.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset (all flops cleared)
//   din    : asynchronous input
//   rise   : high for one clk cycle when the synchronized input goes 0 -> 1
//            (combinational from the last sync flop and the history flop)
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/clock_monitor.sv
// Monitors an asynchronous clock in the clk domain: measures its period in
// clk cycles, and reports lock, loss-of-clock and out-of-range status.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   en             : monitor enable; low forces the FSM to idle
//   mon_clk        : monitored clock, asynchronous to clk
//   min_period     : lowest acceptable period (inclusive), quasi-static
//   max_period     : highest acceptable period (inclusive), quasi-static
//   period         : most recent measured period
//   period_valid   : one-cycle pulse when period updates
//   edge_pulse     : one-cycle pulse per detected mon_clk rising edge
//   locked         : LOCK_COUNT consecutive in-range periods seen
//   clk_lost       : no edge seen for TIMEOUT cycles
//   out_of_range   : last measured period outside [min_period, max_period]
module clock_monitor
    import clock_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = DefaultCntW,
    parameter int unsigned TIMEOUT     = DefaultTimeout,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mon_clk,
    input  logic [CNT_W-1:0] min_period,
    input  logic [CNT_W-1:0] max_period,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             edge_pulse,
    output logic             locked,
    output logic             clk_lost,
    output logic             out_of_range
);

    localparam int unsigned      GoodW      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [GoodW-1:0] LockVal    = GoodW'(LOCK_COUNT);

    mon_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [GoodW-1:0] good_q;

    logic             rise;
    logic             in_range;
    logic             timeout;
    logic [CNT_W-1:0] cnt_inc;
    logic [GoodW-1:0] good_inc;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mon_clk),
        .rise  (rise)
    );

    // min_period > max_period makes this false for every count
    assign in_range = (cnt_q >= min_period) && (cnt_q <= max_period);
    assign timeout  = (cnt_q >= TimeoutVal);
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    assign good_inc = (good_q == LockVal) ? good_q : good_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            good_q       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            edge_pulse   <= 1'b0;
            locked       <= 1'b0;
            clk_lost     <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            edge_pulse   <= rise;
            if (!en) begin
                // Disable wins over any edge or timeout this cycle
                state_q      <= StIdle;
                cnt_q        <= '0;
                good_q       <= '0;
                locked       <= 1'b0;
                clk_lost     <= 1'b0;
                out_of_range <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StArm;
                        cnt_q   <= '0;
                    end
                    StArm: begin
                        // First edge only starts the count; nothing to measure yet
                        if (rise) begin
                            state_q <= StMeasure;
                            cnt_q   <= CntOne;
                        end else if (timeout) begin
                            state_q  <= StLost;
                            cnt_q    <= cnt_inc;
                            clk_lost <= 1'b1;
                            locked   <= 1'b0;
                            good_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StMeasure: begin
                        if (rise) begin
                            period       <= cnt_q;
                            period_valid <= 1'b1;
                            cnt_q        <= CntOne;
                            if (in_range) begin
                                out_of_range <= 1'b0;
                                good_q       <= good_inc;
                                locked       <= (good_inc == LockVal);
                            end else begin
                                out_of_range <= 1'b1;
                                good_q       <= '0;
                                locked       <= 1'b0;
                            end
                        end else if (timeout) begin
                            state_q  <= StLost;
                            cnt_q    <= cnt_inc;
                            clk_lost <= 1'b1;
                            locked   <= 1'b0;
                            good_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    StLost: begin
                        // Recovery edge restarts the count but yields no period
                        if (rise) begin
                            state_q  <= StMeasure;
                            cnt_q    <= CntOne;
                            clk_lost <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Receiving-end counterpart to the catalog clock generator.
- Observes an externally generated, asynchronous clock (`mon_clk`) in the `clk` domain.
- Synchronizes it, detects its rising edges and measures its period in `clk` cycles.
- Reports lock, loss-of-clock and out-of-range status.
- Used by testbenches and by system logic that must qualify a generated or divided clock before use.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `mon_clk` (minimum 2).
- CNT_W, 16, width of the period counter and period-related ports.
- TIMEOUT, 1000, `clk` cycles without a detected edge before loss is declared (must be less than 2^CNT_W-1).
- LOCK_COUNT, 4, consecutive in-range periods required to assert `locked`.

Ports:
- clk, input, 1, system clock; all logic is in this domain.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, monitor enable.
- mon_clk, input, 1, monitored clock; asynchronous to `clk`.
- min_period, input, CNT_W, lowest acceptable period in `clk` cycles, inclusive; quasi-static.
- max_period, input, CNT_W, highest acceptable period, inclusive; quasi-static.
- period, output, CNT_W, most recent measured period.
- period_valid, output, 1, one-cycle pulse when `period` updates.
- edge_pulse, output, 1, one-cycle pulse per detected `mon_clk` rising edge.
- locked, output, 1, `mon_clk` has been stable and in range.
- clk_lost, output, 1, no edge seen for TIMEOUT cycles.
- out_of_range, output, 1, last measured period was outside [min_period, max_period].

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - all outputs 0;
  - synchronizer and edge-history flops 0;
  - counter and good-count 0;
  - FSM in IDLE.
- Synchronizer and edge detection:
  - `mon_clk` passes through SYNC_STAGES flops, plus one history flop.
  - An edge is detected when synced=1 and history=0.
  - `edge_pulse` is registered, so it asserts SYNC_STAGES+1 cycles after `mon_clk` is sampled high.
- Counter:
  - Loaded with 1 on every detected edge; increments by 1 otherwise.
  - Saturates at 2^CNT_W-1 and never wraps.
  - For `mon_clk` = `clk`/N, the measured period is exactly N.
- FSM states IDLE, ARM, MEASURE, LOST:
  - IDLE: counter held at 0; `locked`, `clk_lost`, `out_of_range` = 0; `period` retains its last value. `en`=1 → ARM.
  - ARM: waits for the first edge; no measurement is made. On edge → MEASURE with counter=1. Counter reaches TIMEOUT → LOST.
  - MEASURE, on edge:
    - `period` ← counter and `period_valid` pulses, both in the cycle after detection (same cycle as `edge_pulse`).
    - Counter ← 1.
    - If in range: `out_of_range` ← 0 and good-count increments, saturating at LOCK_COUNT; `locked` ← 1 when good-count reaches LOCK_COUNT.
    - If out of range: `out_of_range` ← 1, good-count ← 0, `locked` ← 0.
  - MEASURE, no edge: counter reaches TIMEOUT → LOST.
  - LOST:
    - On entry: `clk_lost` ← 1, `locked` ← 0, good-count ← 0.
    - On edge: `clk_lost` ← 0, counter ← 1, → MEASURE; no `period` update for that edge.
  - `en`=0 in any state → IDLE next cycle, overriding an edge or timeout in the same cycle.
- Range compare is unsigned and inclusive. If min_period > max_period, every period is out of range.
- Glitches shorter than one `clk` period may be missed; this is by design.
- Reset mid-operation returns everything to reset values immediately; no partial measurement survives.

Decomposition:
- Shared package `clock_pkg`:
  - FSM state enum `mon_state_t` (IDLE, ARM, MEASURE, LOST);
  - default constants for CNT_W and TIMEOUT.
- One natural sub-module: `sync_edge_det`, the parameterized SYNC_STAGES synchronizer plus rising-edge pulse. It is reusable elsewhere in the catalog.
- The top level holds the counter, compare and FSM.

Test Plan:
- Lock on clean clock:
  - Stimulus: SYNC_STAGES=2, min_period=8, max_period=12, `mon_clk`=`clk`/10, `en`=1.
  - Response: first `period_valid` shows period=10, as do all later ones; `locked` rises with the 4th `period_valid`; `out_of_range` stays 0.
- Out-of-range period:
  - Stimulus: after lock, change `mon_clk` to `clk`/20.
  - Response: next `period_valid` shows period=20 with `out_of_range`=1 and `locked`=0. Returning to `clk`/10 clears `out_of_range` at once and re-locks after 4 periods.
- Clock loss and recovery:
  - Stimulus: hold `mon_clk` low after a lock.
  - Response: `clk_lost`=1 exactly 1000 cycles after the last `edge_pulse`, with `locked`=0. On restart, `clk_lost` clears on the first `edge_pulse`; the first new `period_valid` comes on the second edge.
- Disable mid-measurement:
  - Stimulus: drop `en` while locked.
  - Response: next cycle `locked`/`clk_lost`/`out_of_range`=0 and `period` is held. Re-enabling requires an ARM edge, then LOCK_COUNT periods.
- Asynchronous reset mid-operation:
  - Stimulus: pulse `rst_n`=0 between `clk` edges.
  - Response: all outputs 0 immediately, with no `period_valid` until two edges after release.
- Boundary and saturation:
  - Stimulus: period exactly 8 and exactly 12; separately, CNT_W=4 with TIMEOUT=14.
  - Response: 8 and 12 are both in range. In the CNT_W=4 case, LOST is entered and the counter never wraps to 0.
